// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter/rotator (LSL/LSR/ASR/ROR), one log2 shift level per stage.
// Define BARRELSHIFT_CARRY_EN to build carry-out tracking; otherwise out_carry is tied to 0.

module barrel_shift_stage #(
   parameter int WIDTH = 8,
   parameter int SH    = 1
) (
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             sbit
);
   always_comb begin
      q    = d;
      sbit = 1'b0;
      if (en) begin
         unique case (mode)
            2'b00: begin q = {d[WIDTH-SH-1:0], {SH{1'b0}}};   sbit = d[WIDTH-SH]; end
            2'b01: begin q = {{SH{1'b0}}, d[WIDTH-1:SH]};     sbit = d[SH-1];     end
            2'b10: begin q = {{SH{d[WIDTH-1]}}, d[WIDTH-1:SH]}; sbit = d[SH-1];   end
            2'b11: begin q = {d[SH-1:0], d[WIDTH-1:SH]};      sbit = d[SH-1];     end
         endcase
      end
   end
endmodule

module barrel_shifter_pipe #(
   parameter int WIDTH = 8,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [SHW-1:0]   in_shmag,
   input  logic [1:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_carry
);
   localparam int ST = SHW;

   // Slot 0 captures the raw operation; slot k+1 holds the result after shift level k.
   logic [ST:0]                vld_pipe;
   logic [ST:0][WIDTH-1:0]     dat_pipe;
   logic [ST-1:0][SHW-1:0]     mag_pipe;
   logic [ST-1:0][1:0]         mode_pipe;
   logic [ST-1:0][WIDTH-1:0]   shf;
   logic [ST-1:0]              sbit;
   logic                       adv;

   assign adv       = out_ready | ~vld_pipe[ST];
   assign in_ready  = adv;
   assign out_valid = vld_pipe[ST];
   assign out_data  = dat_pipe[ST];

   for (genvar k = 0; k < ST; k++) begin : g_stage
      barrel_shift_stage #(.WIDTH(WIDTH), .SH(1 << k)) u_stage (
         .en   (mag_pipe[k][k]),
         .mode (mode_pipe[k]),
         .d    (dat_pipe[k]),
         .q    (shf[k]),
         .sbit (sbit[k])
      );
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_pipe  <= '0;
         dat_pipe  <= '0;
         mag_pipe  <= '0;
         mode_pipe <= '0;
      end else if (adv) begin
         vld_pipe     <= {vld_pipe[ST-1:0], in_valid};
         dat_pipe[0]  <= in_data;
         mag_pipe[0]  <= in_shmag;
         mode_pipe[0] <= in_mode;
         for (int k = 0; k < ST; k++) dat_pipe[k+1] <= shf[k];
         for (int k = 1; k < ST; k++) begin
            mag_pipe[k]  <= mag_pipe[k-1];
            mode_pipe[k] <= mode_pipe[k-1];
         end
      end
   end

   // Only the top magnitude bit matters in the last shift level.
   logic unused_mag;
   assign unused_mag = ^mag_pipe[ST-1];

`ifdef BARRELSHIFT_CARRY_EN
   // A level with its bit clear keeps the carry from the earlier level.
   logic [ST:0] cy_pipe;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cy_pipe <= '0;
      end else if (adv) begin
         cy_pipe[0] <= 1'b0;
         for (int k = 0; k < ST; k++)
            cy_pipe[k+1] <= mag_pipe[k][k] ? sbit[k] : cy_pipe[k];
      end
   end
   assign out_carry = cy_pipe[ST];
`else
   logic unused_sbit;
   assign unused_sbit = ^sbit;
   assign out_carry   = 1'b0;
`endif

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Scoreboard bench for barrel_shifter_pipe (WIDTH=8): directed vectors, stall, mid-flight reset.
// Carry expectations follow BARRELSHIFT_CARRY_EN.

module tb_barrel_shifter_pipe;
`ifdef BARRELSHIFT_CARRY_EN
   localparam bit CY_EN = 1'b1;
`else
   localparam bit CY_EN = 1'b0;
`endif
   localparam logic [1:0] LSL = 2'b00, LSR = 2'b01, ASR = 2'b10, ROR = 2'b11;

   logic       clk, rst, in_valid, in_ready, out_valid, out_ready, out_carry;
   logic [7:0] in_data, out_data;
   logic [2:0] in_shmag;
   logic [1:0] in_mode;

   typedef struct { logic [7:0] d; logic c; } exp_t;
   exp_t q[$];
   exp_t mon_e;
   int   n_chk = 0;
   int   n_err = 0;

   barrel_shifter_pipe #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_shmag(in_shmag), .in_mode(in_mode),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_carry(out_carry)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Monitor: every output transfer is matched against the queue head.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (q.size() == 0) begin
            n_chk++; n_err++;
            $display("FAIL unexpected_output: got data %0h, expected no output", out_data);
         end else begin
            mon_e = q.pop_front();
            chk("out_data", 32'(out_data), 32'(mon_e.d));
            chk("out_carry", 32'(out_carry), 32'(mon_e.c));
         end
      end
   end

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic issue(input logic [7:0] d, input logic [2:0] m, input logic [1:0] md,
                        input logic [7:0] ed, input logic ec);
      int t;
      in_valid = 1'b1; in_data = d; in_shmag = m; in_mode = md;
      t = 0;
      @(negedge clk);
      while (!in_ready && t < 50) begin t++; @(negedge clk); end
      if (!in_ready) begin
         n_chk++; n_err++;
         $display("FAIL accept_timeout: in_ready stayed 0, required 1");
      end
      q.push_back('{ed, CY_EN ? ec : 1'b0});
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // After issue(): out_valid must rise exactly 3 edges after acceptance.
   task automatic lat_check(input string nm);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk({nm, "_early_valid"}, 32'(out_valid), 32'd0);
      end
      @(negedge clk);
      chk({nm, "_valid_at_3"}, 32'(out_valid), 32'd1);
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (q.size() != 0 && t < 40) begin @(posedge clk); t++; end
      #1;
      n_chk++;
      if (q.size() != 0) begin
         n_err++;
         $display("FAIL drain: %0d results outstanding, required 0", q.size());
      end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = '0; in_shmag = '0; in_mode = '0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_out_carry", 32'(out_carry), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);
      chk("post_rst_out_valid", 32'(out_valid), 32'd0);
      @(posedge clk); #1;

      // Single op with latency check
      issue(8'hAD, 3'd5, LSL, 8'hA0, 1'b1);
      lat_check("lsl5");
      drain();

      // Back-to-back stream of directed vectors
      @(posedge clk); #1;
      issue(8'hAD, 3'd7, LSR, 8'h01, 1'b0);
      issue(8'hAD, 3'd6, ASR, 8'hFE, 1'b1);
      issue(8'hAD, 3'd4, ROR, 8'hDA, 1'b1);
      issue(8'hAD, 3'd1, LSL, 8'h5A, 1'b1);
      issue(8'hAD, 3'd1, LSR, 8'h56, 1'b1);
      issue(8'h2D, 3'd7, ASR, 8'h00, 1'b0);
      issue(8'hAD, 3'd7, ROR, 8'h5B, 1'b0);
      issue(8'h01, 3'd7, LSL, 8'h80, 1'b0);
      issue(8'hAD, 3'd0, LSL, 8'hAD, 1'b0);
      issue(8'hAD, 3'd0, LSR, 8'hAD, 1'b0);
      issue(8'hAD, 3'd0, ASR, 8'hAD, 1'b0);
      issue(8'hAD, 3'd0, ROR, 8'hAD, 1'b0);
      drain();

      // Stall: pipeline fills with four ops, then holds for 5 cycles
      @(posedge clk); #1;
      out_ready = 1'b0;
      issue(8'hAD, 3'd5, LSL, 8'hA0, 1'b1);
      issue(8'hAD, 3'd7, LSR, 8'h01, 1'b0);
      issue(8'hAD, 3'd6, ASR, 8'hFE, 1'b1);
      issue(8'hAD, 3'd4, ROR, 8'hDA, 1'b1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_out_valid", 32'(out_valid), 32'd1);
         chk("stall_out_data", 32'(out_data), 32'hA0);
         chk("stall_out_carry", 32'(out_carry), 32'(CY_EN));
         chk("stall_in_ready", 32'(in_ready), 32'd0);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("release_out_valid", 32'(out_valid), 32'd1);
      end
      drain();

      // Reset with two ops in flight
      @(posedge clk); #1;
      issue(8'hAD, 3'd5, LSL, 8'hA0, 1'b1);
      issue(8'hAD, 3'd4, ROR, 8'hDA, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_out_data", 32'(out_data), 32'd0);
      q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("no_stale_valid", 32'(out_valid), 32'd0);
      end
      @(posedge clk); #1;
      issue(8'hAD, 3'd6, ASR, 8'hFE, 1'b1);
      lat_check("post_rst");
      drain();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/barrel_shifter_pipe.md
# barrel_shifter_pipe

Parametrised, pipelined barrel shifter/rotator with valid/ready handshakes on both sides. It generalises the team's 8-bit combinational barrel shifter to any power-of-two width and four shift modes, and reports a carry-out (the last bit shifted out). It registers one log2 shift level per pipeline stage and sustains one operation per clock. It sits between the operand-issue logic and the ALU result mux.

## Interface
- WIDTH, 8, data width; power of two, minimum 4.
- SHW, $clog2(WIDTH), shift-magnitude width; derived, do not override.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream presents an operation.
- in_ready  out  1  block accepts an operation this cycle.
- in_data  in  WIDTH  operand.
- in_shmag  in  SHW  shift amount, 0..WIDTH-1.
- in_mode  in  2  shift mode:
  - 00: LSL (logical shift left).
  - 01: LSR (logical shift right).
  - 10: ASR (arithmetic shift right).
  - 11: ROR (rotate right).
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts the result.
- out_data  out  WIDTH  shifted result.
- out_carry  out  1  last bit shifted out.

## Operation
- Pipeline structure:
  - SHW stages.
  - Stage k applies a shift of 2^k in the captured mode when bit k of shmag is set; otherwise it passes the data through.
  - Each stage register holds valid, data, residual shmag, mode and carry.
- Handshake:
  - advance = out_ready | ~out_valid.
  - in_ready = advance.
  - A transfer occurs when in_valid & in_ready, and on the output side when out_valid & out_ready.
  - When advance is high, every stage loads from its predecessor. Stage 0 loads the input and takes valid = in_valid.
  - When advance is low, all stages hold.
- Fill rules:
  - LSL and LSR fill with 0.
  - ASR fills with in_data[WIDTH-1].
  - ROR wraps the low bits to the top.
- Carry for shmag = n > 0:
  - LSL: in_data[WIDTH-n].
  - LSR, ASR and ROR: in_data[n-1].
- Carry for shmag = 0: 0, and out_data = in_data in every mode.
- No overflow or saturation flags are produced. Results are exactly WIDTH bits.
- Order is strictly preserved and no operation is ever dropped or duplicated.

## Timing
- Reset: all stage valid bits are 0 and all data/carry registers are 0. In-flight operations are discarded.
- Outputs during and right after reset: out_valid=0, out_data=0, out_carry=0. in_ready=1 after reset.
- Latency: an operation accepted at edge N shows out_valid=1 after edge N+SHW when it is not stalled (3 cycles at WIDTH=8).
- Throughput: one operation per cycle while out_ready=1.
- Stall: while out_valid=1 and out_ready=0, out_data, out_carry and all stages are frozen, and in_ready=0.
- Bubbles: when in_valid=0, an invalid slot propagates through the pipeline. Bubbles are not collapsed.
- Same-cycle events: input acceptance and output consumption in the same cycle are both legal.
- Reset asserted mid-stream clears the pipeline immediately (asynchronously). out_valid drops in the same cycle.

## Configuration
- BARRELSHIFT_CARRY_EN defined: carry tracking is built into every stage and out_carry behaves as specified above.
- BARRELSHIFT_CARRY_EN undefined: the carry registers and logic are omitted and out_carry is tied to 0. The port remains present, and data behaviour and timing are unchanged.

## Test plan
- WIDTH=8, in_data=1010_1101:
  - shmag=5, LSL -> out_data=1010_0000, out_carry=1, out_valid 3 cycles after acceptance.
  - shmag=7, LSR -> out_data=0000_0001, out_carry=0.
  - shmag=6, ASR -> out_data=1111_1110, out_carry=1.
  - shmag=4, ROR -> out_data=1101_1010, out_carry=1.
  - shmag=0, each of the four modes -> out_data=1010_1101, out_carry=0.
- Back-to-back stall: issue the four operations above on consecutive cycles with out_ready=0 from the first result for 5 cycles -> out_valid held, out_data stable, in_ready=0, then the results arrive in issue order, one per cycle.
- Reset mid-flight: assert rst while 2 operations are in flight -> out_valid=0 immediately. After release, no stale result appears and a new operation completes with latency 3.
- Build without BARRELSHIFT_CARRY_EN: rerun the first scenario -> identical out_data with out_carry=0 throughout.
